// File: rtl/shiftreg_clk_sequencer_if.sv
// Burst request / serial-clock status bundle between the register-access
// control logic (master) and the sclk burst sequencer (slave).
interface shiftreg_clk_sequencer_if #(
    parameter int DIV_WIDTH   = 6,
    parameter int NBITS_WIDTH = 16
);
    logic                   start;
    logic                   abort;
    logic [DIV_WIDTH-1:0]   div;
    logic [NBITS_WIDTH-1:0] nbits;
    logic                   sclk;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic [NBITS_WIDTH-1:0] bit_idx;
    logic                   busy;
    logic                   done;
    logic                   aborted;

    modport master (
        output start, abort, div, nbits,
        input  sclk, sclk_rise, sclk_fall, bit_idx, busy, done, aborted
    );

    modport slave (
        input  start, abort, div, nbits,
        output sclk, sclk_rise, sclk_fall, bit_idx, busy, done, aborted
    );
endinterface

// File: rtl/shiftreg_clk_sequencer.sv
// Bounded burst of divided serial clocks (period 2**div_eff clk_in cycles)
// with rise/fall strobes, bit counter and done/aborted pulses.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no burst; sclk low; waiting for start
// S_LEAD   | sclk low for one half-period before the first rise
// S_RUN_HI | sclk high half-period
// S_RUN_LO | sclk low half-period between two bits
// S_TRAIL  | sclk low for one half-period after the last fall
// S_FINISH | one-cycle completion for a zero-length burst
module shiftreg_clk_sequencer #(
    parameter int DIV_WIDTH   = 6,
    parameter int NBITS_WIDTH = 16,
    parameter int TIMER_WIDTH = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    shiftreg_clk_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_RUN_HI,
        S_RUN_LO,
        S_TRAIL,
        S_FINISH
    } state_t;

    state_t                 state_q;
    logic [TIMER_WIDTH-1:0] timer_q;
    logic [TIMER_WIDTH-1:0] half_q;
    logic [NBITS_WIDTH-1:0] nbits_q;
    logic [NBITS_WIDTH-1:0] bit_idx_q;
    logic                   sclk_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   aborted_q;

    logic [31:0]            div_ext;
    logic [31:0]            div_eff;
    logic [63:0]            half_full;
    logic [TIMER_WIDTH-1:0] half_m1_d;
    logic [TIMER_WIDTH-1:0] timer_dec_d;
    logic [NBITS_WIDTH-1:0] idx_inc_d;
    logic                   timer_zero;

    // div=0 would need sclk to toggle every clk_in edge, which a flop cannot do.
    always_comb begin
        div_ext = 32'(bus.div);
        if (div_ext == 32'd0) begin
            div_eff = 32'd1;
        end else if (div_ext > 32'(TIMER_WIDTH)) begin
            div_eff = 32'(TIMER_WIDTH);
        end else begin
            div_eff = div_ext;
        end
        half_full   = (64'd1 << (div_eff - 32'd1)) - 64'd1;
        half_m1_d   = half_full[TIMER_WIDTH-1:0];
        timer_dec_d = timer_q - TIMER_WIDTH'(1);
        idx_inc_d   = bit_idx_q + NBITS_WIDTH'(1);
        timer_zero  = (timer_q == '0);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            half_q    <= '0;
            nbits_q   <= '0;
            bit_idx_q <= '0;
            sclk_q    <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (state_q != S_IDLE && bus.abort) begin
                state_q   <= S_IDLE;
                timer_q   <= '0;
                sclk_q    <= 1'b0;
                busy_q    <= 1'b0;
                aborted_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            busy_q    <= 1'b1;
                            bit_idx_q <= '0;
                            nbits_q   <= bus.nbits;
                            half_q    <= half_m1_d;
                            timer_q   <= half_m1_d;
                            state_q   <= (bus.nbits == '0) ? S_FINISH : S_LEAD;
                        end
                    end
                    S_FINISH: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        timer_q <= '0;
                        state_q <= S_IDLE;
                    end
                    S_LEAD, S_RUN_LO: begin
                        if (timer_zero) begin
                            sclk_q  <= 1'b1;
                            rise_q  <= 1'b1;
                            timer_q <= half_q;
                            state_q <= S_RUN_HI;
                        end else begin
                            timer_q <= timer_dec_d;
                        end
                    end
                    S_RUN_HI: begin
                        if (timer_zero) begin
                            sclk_q    <= 1'b0;
                            fall_q    <= 1'b1;
                            bit_idx_q <= idx_inc_d;
                            timer_q   <= half_q;
                            state_q   <= (idx_inc_d == nbits_q) ? S_TRAIL : S_RUN_LO;
                        end else begin
                            timer_q <= timer_dec_d;
                        end
                    end
                    S_TRAIL: begin
                        if (timer_zero) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            timer_q <= timer_dec_d;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.sclk      = sclk_q;
    assign bus.sclk_rise = rise_q;
    assign bus.sclk_fall = fall_q;
    assign bus.bit_idx   = bit_idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_shiftreg_clk_sequencer.sv
// Bench for shiftreg_clk_sequencer: directed scenarios plus random bursts,
// compared every cycle against a closed-form waveform model.
module tb_shiftreg_clk_sequencer;

    localparam int DW = 6;
    localparam int NW = 16;
    localparam int TW = 32;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    shiftreg_clk_sequencer_if #(.DIV_WIDTH(DW), .NBITS_WIDTH(NW)) bus ();

    shiftreg_clk_sequencer #(
        .DIV_WIDTH  (DW),
        .NBITS_WIDTH(NW),
        .TIMER_WIDTH(TW)
    ) dut (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    // Model: while a burst is active, m_j counts clk_in edges since the
    // accepted start, and every output follows from m_j, H and N.
    bit     m_active;
    longint m_j;
    longint m_h;
    longint m_n;
    longint m_hold;
    bit     m_ab;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint half_of(input int d);
        int de;
        de = (d == 0) ? 1 : ((d > TW) ? TW : d);
        return longint'(1) << (de - 1);
    endfunction

    function automatic longint end_of();
        return (m_n == 0) ? 1 : (2 * m_n + 1) * m_h;
    endfunction

    function automatic longint idx_at(input longint j);
        longint k;
        k = j / (2 * m_h);
        return (k > m_n) ? m_n : k;
    endfunction

    task automatic check_outputs();
        longint e_sclk, e_rise, e_fall, e_idx, e_busy, e_done, e_ab;
        longint per, p, fin;
        e_sclk = 0; e_rise = 0; e_fall = 0; e_busy = 0; e_done = 0;
        e_idx  = m_hold;
        e_ab   = m_ab ? 1 : 0;
        if (m_active) begin
            per    = 2 * m_h;
            fin    = end_of();
            e_ab   = 0;
            e_idx  = idx_at(m_j);
            e_busy = (m_j < fin) ? 1 : 0;
            e_done = (m_j == fin) ? 1 : 0;
            if (m_n > 0 && m_j >= m_h && (m_j - m_h) < m_n * per) begin
                p      = (m_j - m_h) % per;
                e_sclk = (p < m_h) ? 1 : 0;
                e_rise = (p == 0) ? 1 : 0;
            end
            if (m_j > 0 && (m_j % per) == 0 && (m_j / per) <= m_n) e_fall = 1;
        end
        chk("sclk",      longint'(bus.sclk),      e_sclk);
        chk("sclk_rise", longint'(bus.sclk_rise), e_rise);
        chk("sclk_fall", longint'(bus.sclk_fall), e_fall);
        chk("bit_idx",   longint'(bus.bit_idx),   e_idx);
        chk("busy",      longint'(bus.busy),      e_busy);
        chk("done",      longint'(bus.done),      e_done);
        chk("aborted",   longint'(bus.aborted),   e_ab);
    endtask

    // Effect of the coming clk_in edge on the model, given the driven inputs.
    task automatic advance(input bit s, input bit a, input int d, input int n);
        bit ab_now;
        ab_now = 1'b0;
        if (m_active && m_j < end_of()) begin
            if (a) begin
                m_active = 1'b0;
                m_hold   = idx_at(m_j);
                ab_now   = 1'b1;
            end else begin
                m_j++;
            end
        end else begin
            if (m_active) begin
                m_active = 1'b0;
                m_hold   = m_n;
            end
            if (s && !a) begin
                m_active = 1'b1;
                m_j      = 0;
                m_h      = half_of(d);
                m_n      = n;
            end
        end
        m_ab = ab_now;
    endtask

    task automatic step(input bit s, input bit a, input int d, input int n);
        @(negedge clk_in);
        check_outputs();
        bus.start = s;
        bus.abort = a;
        bus.div   = DW'(d);
        bus.nbits = NW'(n);
        advance(s, a, d, n);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++)
            step(1'b0, 1'b0, int'($urandom_range(0, 63)), int'($urandom_range(0, 65535)));
    endtask

    task automatic pulse_reset();
        @(negedge clk_in);
        check_outputs();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #2 rst_n = 1'b0;
        m_active = 1'b0;
        m_hold   = 0;
        m_ab     = 1'b0;
        #1 check_outputs();
        @(negedge clk_in);
        check_outputs();
        rst_n = 1'b1;
        advance(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        int d, n, len;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.div   = '0;
        bus.nbits = '0;
        m_active = 1'b0; m_j = 0; m_h = 1; m_n = 0; m_hold = 0; m_ab = 1'b0;

        repeat (2) @(negedge clk_in);
        check_outputs();
        rst_n = 1'b1;

        // basic burst, H=2
        step(1, 0, 2, 3); idle(16);
        // div=0 and div=1 both give H=1
        step(1, 0, 0, 2); idle(7);
        step(1, 0, 1, 2); idle(7);
        // zero-length burst
        step(1, 0, 4, 0); idle(3);
        // start during busy ignored, restart the cycle after done
        step(1, 0, 2, 3); idle(4); step(1, 0, 5, 3); idle(9);
        step(1, 0, 2, 3); idle(16);
        // abort on the second rise
        step(1, 0, 2, 3); idle(5); step(0, 1, 2, 3); idle(4);
        // asynchronous reset while sclk is high, then a fresh burst
        step(1, 0, 2, 3); idle(2); pulse_reset();
        step(1, 0, 2, 3); idle(16);

        for (int b = 0; b < 60; b++) begin
            d   = int'($urandom_range(0, 3));
            n   = int'($urandom_range(0, 5));
            step(1, 0, d, n);
            len = int'(((n == 0) ? 1 : (2 * n + 1)) * half_of(d)) + int'($urandom_range(0, 3));
            for (int c = 0; c < len; c++)
                step(($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0),
                     int'($urandom_range(0, 63)), int'($urandom_range(0, 7)));
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/shiftreg_clk_sequencer.md
Name: shiftreg_clk_sequencer

Overview:
Generates a bounded burst of divided serial clocks for the shift-register read/write path.
- Accepts a start request with a division factor and a bit count.
- Drives sclk (idle low) for exactly nbits periods of f_clk / 2**div.
- Emits one-cycle rise/fall strobes so the shift datapath can sample and launch bits in the clk_in domain.
- Signals completion with a done pulse.
- Sits between the register-access control logic and the serial shift-register datapath, replacing the free-running divider.

Parameters:
DIV_WIDTH, 6, width of div; sclk period = 2**div_eff clk_in cycles.
NBITS_WIDTH, 16, width of nbits and bit_idx.
TIMER_WIDTH, 32, width of half-period timer; div_eff clamps to TIMER_WIDTH.

Ports:
clk_in  input  1  reference clock; all logic on its rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request; sampled only while busy=0.
abort  input  1  synchronous cancel of the burst in progress.
div  input  DIV_WIDTH  division factor; latched on accepted start.
nbits  input  NBITS_WIDTH  number of sclk periods; latched on accepted start.
sclk  output  1  registered serial clock, low when idle.
sclk_rise  output  1  one-cycle strobe, high in the cycle sclk first reads 1.
sclk_fall  output  1  one-cycle strobe, high in the cycle sclk first reads 0 after a high phase.
bit_idx  output  NBITS_WIDTH  count of completed sclk periods (falls) in current burst.
busy  output  1  high from accepted start until done/abort.
done  output  1  one-cycle pulse at normal burst completion.
aborted  output  1  one-cycle pulse when abort terminates a burst.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE. sclk, sclk_rise, sclk_fall, busy, done and aborted are all 0. bit_idx=0 and the timer is 0. A reset mid-burst kills the burst immediately with no done or aborted pulse.
- Effective division and half-period:
  - div_eff = 1 if div=0 (registered output cannot pass clk_in through).
  - div_eff = min(div, TIMER_WIDTH) otherwise.
  - Half-period H = 2**(div_eff-1) clk_in cycles.
- States: IDLE, LEAD, RUN_HI, RUN_LO, TRAIL, plus a one-cycle completion.
- Timing, with an accepted start sampled at edge E0:
  - busy=1 from E0.
  - bit_idx clears to 0 at E0.
  - LEAD: sclk stays low for H cycles.
  - k-th rise (k=1..N) at edge E0+(2k-1)H. sclk=1 and sclk_rise=1 for that one cycle.
  - k-th fall at edge E0+2kH. sclk=0, sclk_fall=1, and bit_idx=k at that same edge.
  - TRAIL: sclk stays low for H cycles after the N-th fall.
  - At edge E0+(2N+1)H: done=1 for one cycle, busy=0, return to IDLE.
- nbits=0: at E0+1, done=1 and busy=0; no sclk activity.
- start while busy=1 is ignored; the latched div/nbits are unchanged. start and done in the same cycle: start is ignored, because busy is still 1 in that cycle.
- A new start is accepted in the cycle after done (busy=0). Back-to-back bursts therefore have at least H+1 low cycles between the last fall and the next rise.
- abort while busy=1, sampled at edge A:
  - At A: sclk=0, busy=0, aborted=1 for one cycle, done stays 0, state IDLE.
  - bit_idx holds its value for debug.
  - If abort lands on a rise edge, the strobe is suppressed.
- abort while idle has no effect. abort has priority over start in the same cycle.
- div and nbits changing during a burst have no effect.
- The timer reloads H-1 at each phase start and counts down. Phase change happens at timer=0.
- bit_idx never wraps, because nbits ≤ 2**NBITS_WIDTH-1.
- sclk is a flop output, glitch-free, with 50% duty cycle.

Test Plan:
1. Basic burst: div=2, nbits=3, start at E0 -> sclk rises at E0+2,6,10 and falls at E0+4,8,12. sclk_rise/sclk_fall pulse there. bit_idx steps 1,2,3. done at E0+14, busy low at E0+14.
2. div=0 and div=1, nbits=2 -> identical waveforms, H=1: rises at E0+1,3; falls at E0+2,4; done at E0+5.
3. nbits=0, div=4 -> done at E0+1; sclk never high; busy high exactly one cycle.
4. start pulsed at E0+5 during a div=2/nbits=3 burst with div=5 -> ignored; waveform identical to scenario 1. A second start the cycle after done gives its first rise at E0+15+H.
5. abort at E0+6 (coincident with the 2nd rise) in scenario 1 -> sclk=0, no sclk_rise at E0+6, aborted=1 at E0+6, bit_idx=1, done never asserted.
6. rst_n low mid-RUN_HI -> sclk, busy and strobes go 0 asynchronously with no done/aborted. After release, a fresh start with div=2, nbits=3 reproduces scenario 1.
